// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared definitions for the memory port arbiter: the 2-bit arbiter state
//   encoding (idle, granted to I-side, granted to D-side).
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_I = 2'd1,
    S_GRANT_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one off-chip memory port between the I-cache miss path and the
//   D-cache miss/write-back path. One requester is granted at a time. Its
//   command is latched into registered mem_* strobes and held until memory
//   answers with mem_ready. The matching ack is a combinational one-cycle
//   pulse. D-side has priority, but on back-to-back contention the grant
//   alternates. A sticky err_timeout flags a memory that never answers.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   i_req/i_addr        : I-side read request (held until i_ack)
//   i_ack/i_rdata       : I-side completion pulse and read data
//   d_req/d_we/d_addr/
//   d_wdata             : D-side request (refill or write-back)
//   d_ack/d_rdata       : D-side completion pulse and read data
//   mem_read/mem_write  : registered memory strobes, held for the transaction
//   mem_addr/mem_wdata  : registered (latched) address and write data
//   mem_rdata/mem_ready : memory read data and one-cycle completion pulse
//   stall               : some request is pending and not acked this cycle
//   err_timeout         : sticky, memory silent for TIMEOUT granted cycles
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  arb_state_e        state_q, state_d;
  logic              last_d_q, last_d_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              err_q, err_d;

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    cnt_d       = cnt_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    i_ack       = 1'b0;
    d_ack       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // mem_ready arriving here belongs to nobody and is ignored.
        cnt_d = '0;
        // D wins unless it won the previous grant and I is also waiting.
        if (d_req && (!i_req || !last_d_q)) begin
          state_d     = S_GRANT_D;
          last_d_d    = 1'b1;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_read_d  = !d_we;
          mem_write_d = d_we;
        end else if (i_req) begin
          state_d     = S_GRANT_I;
          last_d_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
        end
      end
      S_GRANT_I, S_GRANT_D: begin
        if (mem_ready) begin
          // An ack in the reset cycle would report a transaction that the
          // reset is throwing away, so acks are suppressed while rst is high.
          i_ack       = (state_q == S_GRANT_I) && !rst;
          d_ack       = (state_q == S_GRANT_D) && !rst;
          state_d     = S_IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase

    // Flag the timeout on the same edge the counter reaches its limit; the
    // transaction itself keeps waiting.
    if (cnt_d == CNT_MAX) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_d_q    <= 1'b0;
      cnt_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      cnt_q       <= cnt_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign err_timeout = err_q;

  // Read data is a straight wire; it is only meaningful alongside an ack.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  assign stall = (i_req && !i_ack) || (d_req && !d_ack);

endmodule
